ps2_host_tx: RTL and testbench

- PS/2 host-to-device transmitter. It sends one command byte to the keyboard, for example 0xED (set LEDs) or 0xFF (reset).
- It is the other direction of kb_interface: it drives the shared ps2_clk/ps2_data lines through open-drain enables and reports ack, done or error.
- It sits beside kb_interface in top, in the clk65MHz domain.
- It asserts rx_inhibit while a transfer is active so kb_interface ignores the edges it generates.

---
 rtl/ps2_host_tx_pkg.sv | 26 ++
 rtl/ps2_line_filter.sv | 44 ++++
 rtl/ps2_host_tx.sv | 153 +++++++++++++++
 tb/tb_ps2_host_tx.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_host_tx_pkg.sv
// PS/2 host transmitter shared definitions: FSM states, command bytes, counter widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ps2_host_tx_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      INHIBIT   = 3'd1,
      RTS       = 3'd2,
      DATA      = 3'd3,
      WAIT_IDLE = 3'd4
   } ps2_tx_state_t;

   localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
   localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
   localparam logic [7:0] PS2_ACK         = 8'hFA;

   localparam int INH_W = 13;   // inhibit counter width
   localparam int TO_W  = 20;   // timeout counter width

   // PS/2 frames carry odd parity: data bits plus parity hold an odd count of ones.
   function automatic logic odd_parity(input logic [7:0] b);
      return ~^b;
   endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// PS/2 line conditioner: 2-FF synchronizer, FILTER_LEN-sample stability filter, falling-edge tick.
// Latency: 2 sync cycles + FILTER_LEN samples from a raw level change to the filtered change.
// Backpressure: none; free-running sampler, fall_tick is a one-cycle pulse.
// Ports: clk, reset (async active-low), raw (pin level) -> level (filtered, resets to 1), fall_tick.
module ps2_line_filter #(
   parameter int FILTER_LEN = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic level,
   output logic fall_tick
);

   localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

   logic [1:0]    sync;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync      <= 2'b11;
         cnt       <= '0;
         level     <= 1'b1;
         fall_tick <= 1'b0;
      end else begin
         sync      <= {sync[0], raw};
         fall_tick <= 1'b0;
         // cnt tracks how many consecutive samples disagree with the current level;
         // any agreeing sample restarts the run, so short glitches never get through.
         if (sync[1] == level) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            level     <= sync[1];
            cnt       <= '0;
            fall_tick <= level;   // old level 1 means this change is 1->0
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 8 data + parity + stop, ack check.
// Latency: clock line pulled low the cycle after tx_start; the rest is paced by the device clock.
// Backpressure: tx_start is only accepted in IDLE (tx_busy low); starts while busy are dropped.
// Ports: clk, reset (async active-low), tx_start/tx_data, ps2_clk_in/ps2_data_in (raw pins),
//        ps2_clk_oe/ps2_data_oe (1 = pull low), tx_busy, tx_done, tx_error, rx_inhibit (= tx_busy).
module ps2_host_tx
   import ps2_host_tx_pkg::*;
#(
   parameter int INHIBIT_CYCLES = 7800,
   parameter int TIMEOUT_CYCLES = 975000,
   parameter int FILTER_LEN     = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tx_start,
   input  logic [7:0] tx_data,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   output logic       tx_busy,
   output logic       tx_done,
   output logic       tx_error,
   output logic       rx_inhibit
);

   if (INHIBIT_CYCLES < 2 || INHIBIT_CYCLES > (1 << INH_W)) begin : g_bad_inhibit
      $error("ps2_host_tx: INHIBIT_CYCLES must be in 2..8192");
   end
   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > (1 << TO_W)) begin : g_bad_timeout
      $error("ps2_host_tx: TIMEOUT_CYCLES must be in 1..1048576");
   end

   localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
   localparam logic [INH_W-1:0] INH_PRE  = INH_W'(INHIBIT_CYCLES - 2);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

   ps2_tx_state_t    state;
   logic [7:0]       shreg;
   logic             par;
   logic [3:0]       bitcnt;
   logic [INH_W-1:0] inh_cnt;
   logic [TO_W-1:0]  to_cnt;

   logic clk_lvl, clk_fall;
   logic data_lvl, data_fall_unused;

   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
      .clk       (clk),
      .reset     (reset),
      .raw       (ps2_clk_in),
      .level     (clk_lvl),
      .fall_tick (clk_fall)
   );

   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
      .clk       (clk),
      .reset     (reset),
      .raw       (ps2_data_in),
      .level     (data_lvl),
      .fall_tick (data_fall_unused)
   );

   assign rx_inhibit = tx_busy;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         shreg       <= '0;
         par         <= 1'b0;
         bitcnt      <= '0;
         inh_cnt     <= '0;
         to_cnt      <= '0;
         ps2_clk_oe  <= 1'b0;
         ps2_data_oe <= 1'b0;
         tx_busy     <= 1'b0;
         tx_done     <= 1'b0;
         tx_error    <= 1'b0;
      end else begin
         tx_done  <= 1'b0;
         tx_error <= 1'b0;
         case (state)
            IDLE: begin
               if (tx_start) begin
                  shreg       <= tx_data;
                  par         <= odd_parity(tx_data);
                  inh_cnt     <= '0;
                  bitcnt      <= '0;
                  ps2_clk_oe  <= 1'b1;
                  ps2_data_oe <= 1'b0;
                  tx_busy     <= 1'b1;
                  state       <= INHIBIT;
               end
            end

            INHIBIT: begin
               if (inh_cnt == INH_LAST) begin
                  // release clock with data already low: request-to-send
                  ps2_clk_oe <= 1'b0;
                  to_cnt     <= '0;
                  state      <= RTS;
               end else begin
                  inh_cnt <= inh_cnt + 1'b1;
                  // start bit goes out during the final inhibit cycle
                  if (inh_cnt == INH_PRE) ps2_data_oe <= 1'b1;
               end
            end

            RTS, DATA, WAIT_IDLE: begin
               // timeout wins over everything else, so a coincident ack failure
               // still yields just one tx_error pulse
               if (to_cnt == TO_LAST) begin
                  ps2_clk_oe  <= 1'b0;
                  ps2_data_oe <= 1'b0;
                  tx_busy     <= 1'b0;
                  tx_error    <= 1'b1;
                  state       <= IDLE;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
                  if (state == WAIT_IDLE) begin
                     if (clk_lvl && data_lvl) begin
                        tx_done <= 1'b1;
                        tx_busy <= 1'b0;
                        state   <= IDLE;
                     end
                  end else if (clk_fall) begin
                     // bitcnt holds the number of falling edges already seen
                     if (bitcnt == 4'd10) begin
                        if (!data_lvl) begin
                           state <= WAIT_IDLE;
                        end else begin
                           ps2_data_oe <= 1'b0;
                           tx_busy     <= 1'b0;
                           tx_error    <= 1'b1;
                           state       <= IDLE;
                        end
                     end else begin
                        bitcnt <= bitcnt + 1'b1;
                        state  <= DATA;
                        if (bitcnt < 4'd8)       ps2_data_oe <= ~shreg[bitcnt[2:0]];
                        else if (bitcnt == 4'd8) ps2_data_oe <= ~par;
                        else                     ps2_data_oe <= 1'b0;   // stop bit
                     end
                  end
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain line model, device clock generator and frame capture.
// Latency: n/a.
// Backpressure: n/a.
module tb_ps2_host_tx;
   import ps2_host_tx_pkg::*;

   localparam int INH = 20;
   localparam int TO  = 5000;
   localparam int FL  = 2;

   logic       clk;
   logic       reset;
   logic       tx_start;
   logic [7:0] tx_data;
   logic       ps2_clk_in, ps2_data_in;
   logic       ps2_clk_oe, ps2_data_oe;
   logic       tx_busy, tx_done, tx_error, rx_inhibit;

   logic dev_clk_low, dev_data_low, dev_glitch;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int m_start  = -100000;
   int done_cnt = 0;
   int err_cnt  = 0;
   int oe_run   = 0;
   int last_run = 0;
   logic prev_done = 1'b0;
   logic prev_err  = 1'b0;

   // open-drain wiring: either side pulling low wins
   assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low | dev_glitch);
   assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

   ps2_host_tx #(
      .INHIBIT_CYCLES (INH),
      .TIMEOUT_CYCLES (TO),
      .FILTER_LEN     (FL)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .tx_start    (tx_start),
      .tx_data     (tx_data),
      .ps2_clk_in  (ps2_clk_in),
      .ps2_data_in (ps2_data_in),
      .ps2_clk_oe  (ps2_clk_oe),
      .ps2_data_oe (ps2_data_oe),
      .tx_busy     (tx_busy),
      .tx_done     (tx_done),
      .tx_error    (tx_error),
      .rx_inhibit  (rx_inhibit)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #2;
   endtask

   // expected wire frame: start 0, data LSB first, odd parity, stop 1
   function automatic logic [10:0] model_frame(input logic [7:0] b);
      int ones;
      logic [10:0] f;
      ones = 0;
      f = '0;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) ones++;
         f[i+1] = b[i];
      end
      f[9]  = ((ones % 2) == 0);
      f[10] = 1'b1;
      return f;
   endfunction

   // per-cycle checker; 'since' = host clock edges since the accepted start
   task automatic monitor;
      int since;
      forever begin
         @(negedge clk);
         cyc++;
         if (cyc > 80000) begin
            failures++;
            $display("FAIL watchdog actual=%0d cycles required=<80000", cyc);
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $fatal(1, "watchdog");
         end
         if (!reset) begin
            chk("reset_outputs", {ps2_clk_oe, ps2_data_oe, tx_busy, tx_done, tx_error, rx_inhibit}, 0);
         end else begin
            chk("rx_inhibit_eq_busy", rx_inhibit, tx_busy);
            chk("done_and_error", tx_done & tx_error, 0);
            if (prev_done) begin
               chk("busy_after_done", tx_busy, 0);
               chk("done_one_cycle", tx_done, 0);
            end
            if (prev_err) begin
               chk("busy_after_error", tx_busy, 0);
               chk("error_one_cycle", tx_error, 0);
            end
            since = cyc - m_start - 1;
            if (since == 0) begin
               chk("start_cycle_clk_oe", ps2_clk_oe, 0);
               chk("start_cycle_busy", tx_busy, 0);
            end else if (since >= 1 && since <= INH) begin
               chk("inhibit_clk_oe", ps2_clk_oe, 1);
               chk("inhibit_data_oe", ps2_data_oe, (since == INH) ? 1 : 0);
               chk("inhibit_busy", tx_busy, 1);
            end else if (since == INH + 1) begin
               chk("rts_clk_oe", ps2_clk_oe, 0);
               chk("rts_data_oe", ps2_data_oe, 1);
               chk("rts_busy", tx_busy, 1);
            end
         end
         if (tx_done)  done_cnt++;
         if (tx_error) err_cnt++;
         if (ps2_clk_oe) oe_run++;
         else if (oe_run != 0) begin
            last_run = oe_run;
            oe_run = 0;
         end
         prev_done = tx_done;
         prev_err  = tx_error;
      end
   endtask

   task automatic send_start(input logic [7:0] b);
      tx_data  = b;
      tx_start = 1'b1;
      m_start  = cyc;
      tick;
      tx_start = 1'b0;
   endtask

   // Device: waits for request-to-send, then 11 clocks of 40 low / 40 high.
   // Captures start before clocking and bits 1..10 on rising edges.
   // stop_after < 11 leaves the clock low after that falling edge and returns.
   task automatic device(input int stop_after, input bit ack, input int glitch_rise,
                         output logic [10:0] frame);
      int n;
      frame = '0;
      n = 0;
      while (ps2_clk_oe && n < 100) begin
         tick;
         n++;
      end
      chk("rts_clk_released", ps2_clk_oe, 0);
      chk("rts_start_bit_oe", ps2_data_oe, 1);
      repeat (40) tick;
      frame[0] = ps2_data_in;
      for (int k = 1; k <= 11; k++) begin
         dev_clk_low = 1'b1;
         if (k == stop_after) begin
            repeat (20) tick;
            return;
         end
         repeat (40) tick;
         dev_clk_low = 1'b0;
         if (k <= 10) frame[k] = ps2_data_in;
         if (k == 11) dev_data_low = 1'b0;
         if (k == 10 && ack) begin
            repeat (20) tick;
            dev_data_low = 1'b1;
            repeat (20) tick;
         end else if (k == glitch_rise) begin
            repeat (20) tick;
            dev_glitch = 1'b1;
            tick;
            dev_glitch = 1'b0;
            repeat (19) tick;
         end else begin
            repeat (40) tick;
         end
      end
   endtask

   task automatic full_ack(input string tag, input logic [7:0] b, input logic [10:0] lit);
      logic [10:0] fr;
      done_cnt = 0;
      err_cnt  = 0;
      send_start(b);
      device(99, 1'b1, 0, fr);
      chk({tag, "_frame_model"}, fr, model_frame(b));
      chk({tag, "_frame_literal"}, fr, lit);
      chk({tag, "_done_pulses"}, done_cnt, 1);
      chk({tag, "_error_pulses"}, err_cnt, 0);
      chk({tag, "_busy_idle"}, tx_busy, 0);
      chk({tag, "_lines_released"}, {ps2_clk_oe, ps2_data_oe}, 0);
      chk({tag, "_inhibit_len"}, last_run, INH);
   endtask

   initial begin
      logic [10:0] fr;
      int k, rel, errk;
      reset        = 1'b0;
      tx_start     = 1'b0;
      tx_data      = '0;
      dev_clk_low  = 1'b0;
      dev_data_low = 1'b0;
      dev_glitch   = 1'b0;
      fork
         monitor();
      join_none

      repeat (3) tick;
      chk("rst_clk_oe", ps2_clk_oe, 0);
      chk("rst_data_oe", ps2_data_oe, 0);
      chk("rst_busy", tx_busy, 0);
      chk("rst_done", tx_done, 0);
      chk("rst_error", tx_error, 0);
      chk("rst_rx_inhibit", rx_inhibit, 0);
      reset = 1'b1;
      repeat (5) tick;

      // 1: set-LED command, acked
      full_ack("ed", PS2_CMD_SET_LED, 11'h7DA);
      // 2: parity corners
      full_ack("x00", 8'h00, 11'h600);
      chk("x00_parity", last_run == INH ? 1 : 0, 1);
      full_ack("x01", 8'h01, 11'h402);

      // 3: no ack on the 11th clock
      done_cnt = 0;
      err_cnt  = 0;
      send_start(8'h3C);
      device(99, 1'b0, 0, fr);
      chk("noack_frame", fr, model_frame(8'h3C));
      chk("noack_error_pulses", err_cnt, 1);
      chk("noack_done_pulses", done_cnt, 0);
      chk("noack_lines", {ps2_clk_oe, ps2_data_oe}, 0);
      chk("noack_busy", tx_busy, 0);

      // 4: device silent -> timeout TO cycles after clock release
      done_cnt = 0;
      err_cnt  = 0;
      send_start(8'hA5);
      k = 1; rel = -1; errk = -1;
      while (k < 6000 && errk < 0) begin
         if (rel < 0 && !ps2_clk_oe) rel = k;
         if (tx_error) errk = k;
         tick;
         k++;
      end
      chk("timeout_release_edge", rel, INH + 1);
      chk("timeout_error_edge", errk, INH + 1 + TO);
      chk("timeout_gap", errk - rel, 5000);
      chk("timeout_lines", {ps2_clk_oe, ps2_data_oe}, 0);
      chk("timeout_busy", tx_busy, 0);
      chk("timeout_error_pulses", err_cnt, 1);
      chk("timeout_done_pulses", done_cnt, 0);

      // 5: async reset during bit 4, then a clean reset command
      send_start(PS2_CMD_SET_LED);
      device(4, 1'b1, 0, fr);
      chk("bit4_busy_before_reset", tx_busy, 1);
      #1 reset = 1'b0;
      #1;
      chk("async_rst_clk_oe", ps2_clk_oe, 0);
      chk("async_rst_data_oe", ps2_data_oe, 0);
      chk("async_rst_busy", tx_busy, 0);
      dev_clk_low = 1'b0;
      repeat (3) tick;
      reset = 1'b1;
      repeat (5) tick;
      full_ack("ff", PS2_CMD_RESET, 11'h7FE);

      // 6: start while busy is dropped; 1-cycle clock glitch adds no bit
      done_cnt = 0;
      err_cnt  = 0;
      send_start(8'hA3);
      fork
         device(99, 1'b1, 5, fr);
         begin
            repeat (300) tick;
            tx_data  = 8'h55;
            tx_start = 1'b1;
            tick;
            tx_start = 1'b0;
         end
      join
      chk("ignore_frame_model", fr, model_frame(8'hA3));
      chk("ignore_frame_literal", fr, 11'h746);
      chk("ignore_done_pulses", done_cnt, 1);
      chk("ignore_error_pulses", err_cnt, 0);
      chk("ignore_busy", tx_busy, 0);

      repeat (5) tick;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
